// File: rtl/cory_rsp_route3.sv
// Response router for the 3-port round-robin arbiter: a tag FIFO records the
// port select of each granted request and steers in-order responses back.
module cory_rsp_route3 #(
  parameter int unsigned N = 8,
  parameter int unsigned D = 4,
  localparam int unsigned DW = $clog2(D) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_t_v,
  input  logic [1:0]    i_t_s,
  output logic          o_t_r,
  input  logic          i_r_v,
  input  logic [N-1:0]  i_r_d,
  output logic          o_r_r,
  output logic          o_z0_v,
  output logic [N-1:0]  o_z0_d,
  input  logic          i_z0_r,
  output logic          o_z1_v,
  output logic [N-1:0]  o_z1_d,
  input  logic          i_z1_r,
  output logic          o_z2_v,
  output logic [N-1:0]  o_z2_d,
  input  logic          i_z2_r,
  output logic [DW-1:0] o_cnt,
  output logic          o_err
);

  localparam int unsigned AW = (D > 1) ? $clog2(D) : 1;

  logic [1:0]    tag_mem [D];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [DW-1:0] cnt;
  logic          err;
  logic [1:0]    head;
  logic          nonempty;
  logic          push;
  logic          pop;
  logic          head_rdy;

  assign nonempty = (cnt != '0);
  assign head     = tag_mem[rd_ptr];
  // Full check uses only registered count, keeping response ready off this path.
  assign o_t_r    = !reset && (cnt != DW'(D));
  assign push     = i_t_v && o_t_r;
  assign pop      = i_r_v && o_r_r;

  // Ready of the port addressed by the head tag; tag 3 is a drop sink.
  always_comb begin
    head_rdy = 1'b0;
    case (head)
      2'd0:    head_rdy = i_z0_r;
      2'd1:    head_rdy = i_z1_r;
      2'd2:    head_rdy = i_z2_r;
      default: head_rdy = 1'b1;
    endcase
  end

  assign o_r_r  = nonempty && head_rdy;
  assign o_z0_v = i_r_v && nonempty && (head == 2'd0);
  assign o_z1_v = i_r_v && nonempty && (head == 2'd1);
  assign o_z2_v = i_r_v && nonempty && (head == 2'd2);
  assign o_z0_d = i_r_d;
  assign o_z1_d = i_r_d;
  assign o_z2_d = i_r_d;
  assign o_cnt  = cnt;
  assign o_err  = err;

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= i_t_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + DW'(1);
        2'b01:   cnt <= cnt - DW'(1);
        default: cnt <= cnt;
      endcase
      if (pop && (head == 2'd3)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cory_rsp_route3.sv
// Directed table-driven bench for cory_rsp_route3, plus a hand-written
// steady push/pop sequence across pointer wrap.
module tb_cory_rsp_route3;

  logic       clk;
  logic       reset;
  logic       i_t_v;
  logic [1:0] i_t_s;
  logic       o_t_r;
  logic       i_r_v;
  logic [7:0] i_r_d;
  logic       o_r_r;
  logic       o_z0_v, o_z1_v, o_z2_v;
  logic [7:0] o_z0_d, o_z1_d, o_z2_d;
  logic       i_z0_r, i_z1_r, i_z2_r;
  logic [2:0] o_cnt;
  logic       o_err;

  int n_pass = 0;
  int n_total = 0;

  cory_rsp_route3 #(.N(8), .D(4)) dut (
    .clk(clk), .reset(reset),
    .i_t_v(i_t_v), .i_t_s(i_t_s), .o_t_r(o_t_r),
    .i_r_v(i_r_v), .i_r_d(i_r_d), .o_r_r(o_r_r),
    .o_z0_v(o_z0_v), .o_z0_d(o_z0_d), .i_z0_r(i_z0_r),
    .o_z1_v(o_z1_v), .o_z1_d(o_z1_d), .i_z1_r(i_z1_r),
    .o_z2_v(o_z2_v), .o_z2_d(o_z2_d), .i_z2_r(i_z2_r),
    .o_cnt(o_cnt), .o_err(o_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       tv;
    logic [1:0] ts;
    logic       rv;
    logic [7:0] rd;
    logic [2:0] zr;
    logic       e_tr;
    logic       e_rr;
    logic [2:0] e_zv;
    logic [2:0] e_cnt;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic tv, logic [1:0] ts, logic rv,
                              logic [7:0] rd, logic [2:0] zr, logic e_tr,
                              logic e_rr, logic [2:0] e_zv, logic [2:0] e_cnt,
                              logic e_err);
    vec_t v;
    v.rst = rst; v.tv = tv; v.ts = ts; v.rv = rv; v.rd = rd; v.zr = zr;
    v.e_tr = e_tr; v.e_rr = e_rr; v.e_zv = e_zv; v.e_cnt = e_cnt; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    else
      n_pass++;
  endtask

  task automatic drive(input logic rst, input logic tv, input logic [1:0] ts,
                       input logic rv, input logic [7:0] rd, input logic [2:0] zr);
    reset = rst; i_t_v = tv; i_t_s = ts; i_r_v = rv; i_r_d = rd;
    {i_z2_r, i_z1_r, i_z0_r} = zr;
  endtask

  initial begin
    logic [1:0] exp_q[$];
    logic [1:0] h;

    drive(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 3'b000);

    //        rst tv ts  rv rd     zr      tr rr zv      cnt err
    // reset, then idle
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 3'b000, 0, 0, 3'b000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 3'b000, 1, 0, 3'b000, 0, 0));
    // in-order routing: tags 2,0,1 then three responses
    tbl.push_back(mk(0, 1, 2, 0, 8'h00, 3'b000, 1, 0, 3'b000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 3'b000, 1, 0, 3'b000, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 8'h00, 3'b000, 1, 0, 3'b000, 2, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8'hA1, 3'b111, 1, 1, 3'b100, 3, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8'hB2, 3'b111, 1, 1, 3'b001, 2, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8'hC3, 3'b111, 1, 1, 3'b010, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 3'b000, 1, 0, 3'b000, 0, 0));
    // fill with four tags of 1, fifth push ignored
    tbl.push_back(mk(0, 1, 1, 0, 8'h00, 3'b000, 1, 0, 3'b000, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 8'h00, 3'b000, 1, 0, 3'b000, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 8'h00, 3'b000, 1, 0, 3'b000, 2, 0));
    tbl.push_back(mk(0, 1, 1, 0, 8'h00, 3'b000, 1, 0, 3'b000, 3, 0));
    tbl.push_back(mk(0, 1, 1, 0, 8'h00, 3'b000, 0, 0, 3'b000, 4, 0));
    // port 1 backpressure holds valid and data
    tbl.push_back(mk(0, 0, 0, 1, 8'h55, 3'b101, 0, 0, 3'b010, 4, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8'h55, 3'b101, 0, 0, 3'b010, 4, 0));
    // release: one pop per cycle, space reappears after the first
    tbl.push_back(mk(0, 0, 0, 1, 8'h55, 3'b111, 0, 1, 3'b010, 4, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8'h56, 3'b111, 1, 1, 3'b010, 3, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8'h57, 3'b111, 1, 1, 3'b010, 2, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8'h58, 3'b111, 1, 1, 3'b010, 1, 0));
    // empty stall
    tbl.push_back(mk(0, 0, 0, 1, 8'h59, 3'b111, 1, 0, 3'b000, 0, 0));
    // illegal tag 3: consumed without routing, sticky error
    tbl.push_back(mk(0, 1, 3, 0, 8'h00, 3'b000, 1, 0, 3'b000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8'h66, 3'b000, 1, 1, 3'b000, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 3'b000, 1, 0, 3'b000, 0, 1));
    // three tags outstanding, then reset mid-stream
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 3'b000, 1, 0, 3'b000, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 8'h00, 3'b000, 1, 0, 3'b000, 1, 1));
    tbl.push_back(mk(0, 1, 2, 0, 8'h00, 3'b000, 1, 0, 3'b000, 2, 1));
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 3'b000, 0, 0, 3'b000, 3, 1));
    // response after reset stalls until a new tag exists (no bypass)
    tbl.push_back(mk(0, 0, 0, 1, 8'h77, 3'b111, 1, 0, 3'b000, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 8'h77, 3'b111, 1, 0, 3'b000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8'h77, 3'b111, 1, 1, 3'b010, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 3'b000, 1, 0, 3'b000, 0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].tv, tbl[i].ts, tbl[i].rv, tbl[i].rd, tbl[i].zr);
      #1;
      chk("t_r", i, 32'(o_t_r), 32'(tbl[i].e_tr));
      chk("r_r", i, 32'(o_r_r), 32'(tbl[i].e_rr));
      chk("zv",  i, 32'({o_z2_v, o_z1_v, o_z0_v}), 32'(tbl[i].e_zv));
      chk("cnt", i, 32'(o_cnt), 32'(tbl[i].e_cnt));
      chk("err", i, 32'(o_err), 32'(tbl[i].e_err));
      if (tbl[i].e_zv != 3'b000)
        chk("zd", i, 32'({o_z2_d, o_z1_d, o_z0_d}), 32'({3{tbl[i].rd}}));
    end

    // steady push + pop every cycle across pointer wrap, count fixed at 2
    @(negedge clk); drive(1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 3'b000); exp_q.push_back(2'd0);
    @(negedge clk); drive(1'b0, 1'b1, 2'd1, 1'b0, 8'h00, 3'b000); exp_q.push_back(2'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 2'((i + 2) % 3), 1'b1, 8'(8'h10 + i), 3'b111);
      #1;
      h = exp_q.pop_front();
      exp_q.push_back(2'((i + 2) % 3));
      chk("ss_cnt", i, 32'(o_cnt), 32'd2);
      chk("ss_rr",  i, 32'(o_r_r), 32'd1);
      chk("ss_tr",  i, 32'(o_t_r), 32'd1);
      chk("ss_zv",  i, 32'({o_z2_v, o_z1_v, o_z0_v}), 32'(3'b001 << h));
      chk("ss_zd",  i, 32'(o_z0_d), 32'(8'h10 + i));
    end
    // drain the last two tags
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 2'd0, 1'b1, 8'(8'hE0 + i), 3'b111);
      #1;
      h = exp_q.pop_front();
      chk("dr_cnt", i, 32'(o_cnt), 32'(2 - i));
      chk("dr_zv",  i, 32'({o_z2_v, o_z1_v, o_z0_v}), 32'(3'b001 << h));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 3'b000);
    #1;
    chk("final_cnt", 0, 32'(o_cnt), 32'd0);
    chk("final_err", 0, 32'(o_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cory_rsp_route3.md
Name: cory_rsp_route3

Overview:
- Response-side companion to the 3-port round-robin request arbiter.
- Records, in grant order, the 2-bit port select of every request the arbiter issues, holding them in a tag FIFO.
- Routes the in-order, untagged response stream from the shared slave back to requestor port 0, 1 or 2.
- Sits between the slave response channel and the three requestors' response inputs. All channels use the team's valid/ready handshake.

Parameters:
N, 8, response data width in bits
D, 4, tag FIFO depth (max outstanding requests); power of two, >= 2
DW, $clog2(D)+1, occupancy count width (derived, not overridden)

Ports:
clk  input  1  clock
reset  input  1  synchronous reset, active-high
i_t_v  input  1  tag push valid (driven by the arbiter's request accept)
i_t_s  input  2  port select of the accepted request (0..2)
o_t_r  output  1  tag FIFO can accept; request path must gate its accept with this
i_r_v  input  1  response valid from slave
i_r_d  input  N  response data
o_r_r  output  1  response ready to slave
o_z0_v  output  1  port 0 response valid
o_z0_d  output  N  port 0 response data
i_z0_r  input  1  port 0 response ready
o_z1_v, o_z1_d, i_z1_r  same as port 0, for port 1
o_z2_v, o_z2_d, i_z2_r  same as port 0, for port 2
o_cnt  output  DW  tags outstanding
o_err  output  1  sticky error flag

Behaviour:
- Reset (clk edge with reset=1):
  - FIFO pointers and count cleared; o_err cleared.
  - After reset: o_cnt=0, o_t_r=1, all o_zk_v=0, o_r_r=0.
  - While reset is high: o_t_r=0 and pushes are ignored.
  - Reset mid-operation discards all outstanding tags. A response arriving afterwards stalls and is not routed.
- Push:
  - Occurs on clk edge when i_t_v & o_t_r; writes i_t_s at the write pointer, which wraps mod D.
  - o_t_r = !reset & (count != D). No push-through-pop at full, so there is no combinational path from response ready to o_t_r.
- Head: head tag h = FIFO[read pointer]. Valid only when count != 0.
- Routing (combinational, zero latency, response data not registered):
  - o_zk_v = i_r_v & (count != 0) & (h == k).
  - o_zk_d = i_r_d for all k (data fan-out). Only the selected port sees valid.
  - o_r_r = (count != 0) & ((h==0 & i_z0_r) | (h==1 & i_z1_r) | (h==2 & i_z2_r) | (h==3)).
- Pop: occurs on clk edge when i_r_v & o_r_r; read pointer advances, wrapping mod D.
- Illegal tag 3 at head:
  - The response is consumed (o_r_r=1), dropped, and no o_zk_v is asserted.
  - o_err is set on that pop and stays set until reset.
- Empty FIFO:
  - A response stalls (o_r_r=0, all o_zk_v=0). Not an error.
  - A tag pushed into an empty FIFO becomes head on the next cycle, so the earliest route is 1 cycle after the push edge. There is no bypass.
- Simultaneous push and pop (count neither 0 nor D): count unchanged, both pointers advance.
- o_cnt is the registered count, range 0..D. Count is incremented on push only, decremented on pop only.
- Valid/ready rules:
  - o_zk_v never depends on i_zk_r.
  - Once o_zk_v is asserted it stays with stable data until accepted, provided the slave holds i_r_v and i_r_d stable (slave obligation).
- Ordering: responses are delivered strictly in tag push order. Ports never reorder.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> o_t_r=0 during reset; after release o_t_r=1, o_cnt=0, o_err=0, all o_zk_v=0.
- In-order routing: push tags 2,0,1, then responses 0xA1,0xB2,0xC3 with all i_zk_r=1 -> o_z2_d=0xA1, o_z0_d=0xB2, o_z1_d=0xC3 on consecutive cycles; o_cnt goes 3->0.
- Full/backpressure:
  - Push D=4 tags of 1 -> o_t_r=0 at o_cnt=4; a 5th push with i_t_v=1 is ignored.
  - Hold i_z1_r=0 -> o_r_r=0, o_z1_v=1 with data held.
  - Release i_z1_r -> one pop per cycle; o_t_r=1 after the first pop.
- Simultaneous push/pop across pointer wrap: steady push every cycle plus response every cycle for 20 cycles, tags cycling 0,1,2 -> o_cnt constant, responses land on matching ports, no loss.
- Empty stall and illegal tag:
  - Response with o_cnt=0 -> o_r_r=0 and no routing.
  - Push tag 3 then a response -> response consumed, no o_zk_v, o_err=1 and held until reset.
- Reset mid-stream: 3 tags outstanding, assert reset one cycle -> o_cnt=0; a subsequent response stalls until a new tag is pushed.
